regfile_wb_scheduler: RTL and testbench

//  - Owns the REGISTER write port. Two write-back producers share it: ALU (req 0) and LSU (req 1).
//  - Round-robin arbiter with valid/ready handshake. Registered single write stream into iWriteEn/iRdAddr/iWriteData.
//  - Holds a busy scoreboard of registers with an outstanding write. Issue logic uses it for RAW stalls on rs1/rs2 and WAW stalls on rd.

---
 rtl/regfile_wb_scheduler.sv | 126 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Owns the register-file write port. The ALU and the LSU share it through a
//   round-robin arbiter with a valid/ready handshake. The winner goes through a
//   one-cycle registered stage to write_en/rd_addr/write_data. A busy scoreboard
//   tracks registers that have a write outstanding. Issue stalls on RAW hazards
//   (rs1/rs2) and WAW hazards (rd) against that scoreboard.
//
//   Optional feature: define REGFILE_WB_BYPASS_EN to let an rs1/rs2 match on the
//   write-back in flight proceed without a stall. The match is flagged on
//   rs1_fwd/rs2_fwd, and the consumer then takes write_data as the operand.
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   alu_valid/alu_rd/alu_data/alu_ready   ALU write-back request
//   lsu_valid/lsu_rd/lsu_data/lsu_ready   LSU write-back request
//   issue_valid/issue_rd/rs1_addr/rs2_addr  issuing instruction
//   issue_stall                       issue must hold
//   write_en/rd_addr/write_data       register-file write port
//   rs1_fwd/rs2_fwd                   (bypass build only) operand taken from write_data
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              issue_stall,
`ifdef REGFILE_WB_BYPASS_EN
  output logic              rs1_fwd,
  output logic              rs2_fwd,
`endif
  output logic              write_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] write_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic              pref_lsu;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              grant_alu;
  logic              grant_lsu;
  logic              xfer;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              hit1;
  logic              hit2;
  logic              issue_fire;

  // When both sides request, the side named by pref_lsu wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_valid && (!lsu_valid || !pref_lsu)) grant_alu = 1'b1;
    else if (lsu_valid)                         grant_lsu = 1'b1;
  end

  // A grant implies valid, so ready alone marks a transfer. Readies stay low while in reset.
  assign alu_ready = rst_n & grant_alu;
  assign lsu_ready = rst_n & grant_lsu;
  assign xfer      = alu_ready | lsu_ready;
  assign win_rd    = grant_alu ? alu_rd   : lsu_rd;
  assign win_data  = grant_alu ? alu_data : lsu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_lsu <= 1'b0;
    end else if (alu_valid && lsu_valid && xfer) begin
      pref_lsu <= grant_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en   <= 1'b0;
      rd_addr    <= '0;
      write_data <= '0;
    end else begin
      write_en <= xfer && (win_rd != '0);
      if (xfer) begin
        rd_addr    <= win_rd;
        write_data <= win_data;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_fwd = write_en && (rs1_addr == rd_addr);
  assign rs2_fwd = write_en && (rs2_addr == rd_addr);
  assign hit1    = busy[rs1_addr] & ~rs1_fwd;
  assign hit2    = busy[rs2_addr] & ~rs2_fwd;
`else
  assign hit1    = busy[rs1_addr];
  assign hit2    = busy[rs2_addr];
`endif

  assign issue_stall = rst_n & issue_valid & (hit1 | hit2 | busy[issue_rd]);
  assign issue_fire  = issue_valid & ~issue_stall & (issue_rd != '0);

  // Clear and set target different registers whenever both happen, because a WAW
  // hazard blocks the set. Applying them in this order is therefore safe.
  always_comb begin
    busy_nxt = busy;
    if (write_en)   busy_nxt[rd_addr]  = 1'b0;
    if (issue_fire) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, issue_stall, write_en;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic        rs1_fwd_s, rs2_fwd_s;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .issue_stall(issue_stall),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_fwd(rs1_fwd_s), .rs2_fwd(rs2_fwd_s),
`endif
    .write_en(write_en), .rd_addr(rd_addr), .write_data(write_data)
  );

`ifndef REGFILE_WB_BYPASS_EN
  assign rs1_fwd_s = 1'b0;
  assign rs2_fwd_s = 1'b0;
`endif

  always #5 clk = ~clk;

  // Model state: the side that is preferred when both request, the set of
  // registers with a write outstanding, and the write that is now on the port.
  bit        m_pref_lsu = 1'b0;
  bit        m_busy [32];
  bit        m_we = 1'b0;
  bit [4:0]  m_rd = '0;
  bit [31:0] m_data = '0;

  function automatic bit e_alu_ready();
    return rst_n && alu_valid && (!lsu_valid || !m_pref_lsu);
  endfunction
  function automatic bit e_lsu_ready();
    return rst_n && lsu_valid && (!alu_valid || m_pref_lsu);
  endfunction
  function automatic bit e_fwd(input bit [4:0] rs);
    return BYP && m_we && (rs == m_rd);
  endfunction
  function automatic bit e_stall();
    bit h1, h2, h3;
    h1 = (rs1_addr != 0) && m_busy[rs1_addr] && !e_fwd(rs1_addr);
    h2 = (rs2_addr != 0) && m_busy[rs2_addr] && !e_fwd(rs2_addr);
    h3 = (issue_rd != 0) && m_busy[issue_rd];
    return rst_n && issue_valid && (h1 || h2 || h3);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pref_lsu = 1'b0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      bit ga, gl, st;
      ga = e_alu_ready();
      gl = e_lsu_ready();
      st = e_stall();
      if (m_we) m_busy[m_rd] = 1'b0;
      if (issue_valid && !st && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (ga || gl) begin
        if (alu_valid && lsu_valid) m_pref_lsu = ga;
        m_rd   = ga ? alu_rd : lsu_rd;
        m_data = ga ? alu_data : lsu_data;
        m_we   = (m_rd != 0);
      end else begin
        m_we = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("m_alu_ready", alu_ready, e_alu_ready());
    chk("m_lsu_ready", lsu_ready, e_lsu_ready());
    chk("m_stall", issue_stall, e_stall());
    chk("m_we", write_en, m_we);
    chk("m_rd", rd_addr, m_rd);
    chk("m_data", write_data, m_data);
    if (BYP) begin
      chk("m_fwd1", rs1_fwd_s, e_fwd(rs1_addr));
      chk("m_fwd2", rs2_fwd_s, e_fwd(rs2_addr));
    end
  end

  task automatic mid();
    @(negedge clk);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with ALU requesting, then first write.
    #1;
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hDEADBEEF;
    mid(); chk("rst_we", write_en, 0); chk("rst_alu_ready", alu_ready, 0); chk("rst_stall", issue_stall, 0);
    tick();
    mid(); chk("rst_we2", write_en, 0); chk("rst_alu_ready2", alu_ready, 0);
    tick(); rst_n = 1'b1;
    mid(); chk("t1_accept", alu_ready, 1);
    tick(); alu_valid = 1'b0;
    mid(); chk("t1_we", write_en, 1); chk("t1_rd", rd_addr, 1); chk("t1_data", write_data, 32'hDEADBEEF);
    tick();

    // 2: contention, ALU preferred first, then the pointer flips to the LSU.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFEBABE;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h12345678;
    mid(); chk("t2_alu_first", alu_ready, 1); chk("t2_lsu_wait", lsu_ready, 0);
    tick(); alu_valid = 1'b0;
    mid(); chk("t2_lsu_second", lsu_ready, 1); chk("t2_we_a", write_en, 1);
    chk("t2_rd_a", rd_addr, 5); chk("t2_data_a", write_data, 32'hCAFEBABE);
    tick(); lsu_valid = 1'b0;
    mid(); chk("t2_we_b", write_en, 1); chk("t2_rd_b", rd_addr, 6); chk("t2_data_b", write_data, 32'h12345678);
    tick();
    mid(); chk("t2_idle_we", write_en, 0); chk("t2_hold_rd", rd_addr, 6);
    tick();
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h22;
    mid(); chk("t2b_lsu_pref", lsu_ready, 1); chk("t2b_alu_wait", alu_ready, 0);
    tick(); lsu_valid = 1'b0;
    mid(); chk("t2b_alu_next", alu_ready, 1); chk("t2b_rd9", rd_addr, 9);
    tick(); alu_valid = 1'b0;
    mid(); chk("t2b_rd8", rd_addr, 8); chk("t2b_data8", write_data, 32'h11);
    tick();

    // 3: write to x0 is accepted but never reaches the register file.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    mid(); chk("t3_ready", lsu_ready, 1);
    tick(); lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    mid(); chk("t3_we", write_en, 0); chk("t3_stall", issue_stall, 0);
    tick(); issue_valid = 1'b0;

    // 4: RAW on rs1 until the ALU write-back of x10 commits.
    issue_valid = 1'b1; issue_rd = 5'd10;
    mid(); chk("t4_first_issue", issue_stall, 0);
    tick(); issue_rd = 5'd11; rs1_addr = 5'd10;
    mid(); chk("t4_raw", issue_stall, 1);
    tick();
    mid(); chk("t4_raw_hold", issue_stall, 1);
    tick(); alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hABCD1234;
    mid(); chk("t4_alu_acc", alu_ready, 1); chk("t4_raw_acc", issue_stall, 1);
    tick(); alu_valid = 1'b0;
    mid(); chk("t4_we", write_en, 1); chk("t4_rd", rd_addr, 10); chk("t4_data", write_data, 32'hABCD1234);
    if (BYP) begin
      chk("t4_byp_stall", issue_stall, 0); chk("t4_fwd1", rs1_fwd_s, 1);
    end else begin
      chk("t4_wb_stall", issue_stall, 1);
    end
    tick();
    // With bypass the issue already went at the previous edge, so x11 is busy now.
    mid(); chk("t4_after", issue_stall, BYP ? 1 : 0);
    tick(); issue_valid = 1'b0; rs1_addr = 5'd0;

    // 5: WAW on x7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    mid(); chk("t5_first", issue_stall, 0);
    tick();
    mid(); chk("t5_waw", issue_stall, 1);
    tick(); issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    mid(); chk("t5_lsu_acc", lsu_ready, 1);
    tick(); lsu_valid = 1'b0;
    mid(); chk("t5_we", write_en, 1); chk("t5_rd", rd_addr, 7);
    tick(); issue_valid = 1'b1; issue_rd = 5'd7;
    mid(); chk("t5_cleared", issue_stall, 0);
    tick(); issue_valid = 1'b0;

    // 6: reset during an active write with x3 busy.
    issue_valid = 1'b1; issue_rd = 5'd3;
    mid(); chk("t6_issue", issue_stall, 0);
    tick(); issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mid(); chk("t6_acc", alu_ready, 1);
    tick(); alu_valid = 1'b0;
    chk("t6_we_before", write_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we_reset", write_en, 0); chk("t6_rd_reset", rd_addr, 0);
    mid();
    tick(); rst_n = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd3; rs2_addr = 5'd7;
    mid(); chk("t6_no_stall", issue_stall, 0);
    tick(); issue_valid = 1'b0;
    mid();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
